updown_pulse_gen: RTL

- Front-end conditioner that turns two raw push-button levels (up, down) into clean single-cycle up/down pulses.
- Sits directly upstream of the saturating up/down counter and drives its up_i/down_i.
- Per button: 2-flop synchronizer, debouncer and rising-edge detector.
- Arbitrates simultaneous presses.

---
 rtl/updown_pulse_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/updown_pulse_gen.sv
// updown_pulse_gen: conditions two raw push-button levels into clean single-cycle
// up/down pulses for a downstream saturating up/down counter.
//
// Per button: 2-flop synchronizer -> debouncer -> registered held level -> rising-edge
// detector -> registered pulse. Up and down requests arriving in the same cycle
// cancel each other, so up_o and down_o are never high together.
//
// Optional feature (macro UPDOWN_PULSE_AUTOREPEAT_EN): while exactly one button is held,
// extra pulses fire repeat_delay_p cycles after the edge pulse and then every
// repeat_period_p cycles. Without the macro the repeat parameters are unused.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset, clears every flop
//   up_btn_i     raw asynchronous up-button level
//   down_btn_i   raw asynchronous down-button level
//   up_o         single-cycle up pulse (registered)
//   down_o       single-cycle down pulse (registered)
//   up_held_o    debounced up level (registered)
//   down_held_o  debounced down level (registered)
module updown_pulse_gen #(
    parameter int unsigned debounce_p      = 4,
    parameter int unsigned repeat_delay_p  = 16,
    parameter int unsigned repeat_period_p = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic up_btn_i,
    input  logic down_btn_i,
    output logic up_o,
    output logic down_o,
    output logic up_held_o,
    output logic down_held_o
);

    if (debounce_p < 1 || repeat_delay_p < 1 || repeat_period_p < 1) begin : gen_param_check
        $error("updown_pulse_gen: all parameters must be >= 1");
    end

    localparam int unsigned     CntW    = $clog2(debounce_p + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(debounce_p - 1);

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]      btn_raw;
    logic [1:0]      meta_q, sync_q;
    logic [1:0]      stable_q, stable_d;
    logic [CntW-1:0] cnt_q [2];
    logic [CntW-1:0] cnt_d [2];
    logic [1:0]      held_q, held_prev_q;
    logic [1:0]      rise;
    logic [1:0]      req;
    logic [1:0]      pulse_q, pulse_d;

    assign btn_raw = {down_btn_i, up_btn_i};

    // A new level is accepted only after debounce_p consecutive mismatching cycles;
    // any cycle agreeing with the accepted level restarts the count.
    always_comb begin : debounce
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    stable_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = held_q & ~held_prev_q;

`ifdef UPDOWN_PULSE_AUTOREPEAT_EN
    localparam int unsigned RepMax = (repeat_delay_p > repeat_period_p) ? repeat_delay_p
                                                                        : repeat_period_p;
    localparam int unsigned     RepW       = $clog2(RepMax + 1);
    localparam logic [RepW-1:0] DelayLast  = RepW'(repeat_delay_p - 1);
    localparam logic [RepW-1:0] PeriodLast = RepW'(repeat_period_p - 1);

    logic [RepW-1:0] rep_cnt_q [2];
    logic [RepW-1:0] rep_cnt_d [2];
    logic [1:0]      rep_phase_q, rep_phase_d;
    logic [1:0]      rep_fire, rep_run, other_held;

    assign other_held = {held_q[0], held_q[1]};
    // Counting starts the cycle after the edge pulse is requested, so a match on
    // DelayLast lands exactly repeat_delay_p cycles after that pulse.
    assign rep_run    = held_q & held_prev_q & ~other_held;

    always_comb begin : auto_repeat
        for (int i = 0; i < 2; i++) begin
            rep_cnt_d[i]   = '0;
            rep_phase_d[i] = 1'b0;
            rep_fire[i]    = 1'b0;
            if (rep_run[i]) begin
                rep_phase_d[i] = rep_phase_q[i];
                if (rep_cnt_q[i] == (rep_phase_q[i] ? PeriodLast : DelayLast)) begin
                    rep_fire[i]    = 1'b1;
                    rep_phase_d[i] = 1'b1;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rep_cnt_q   <= '{default: '0};
            rep_phase_q <= '0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    assign req = rise | rep_fire;
`else
    assign req = rise;
`endif

    // Simultaneous requests cancel rather than pick a winner.
    assign pulse_d = {req[1] & ~req[0], req[0] & ~req[1]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q      <= '0;
            sync_q      <= '0;
            stable_q    <= '0;
            cnt_q       <= '{default: '0};
            held_q      <= '0;
            held_prev_q <= '0;
            pulse_q     <= '0;
        end else begin
            meta_q      <= btn_raw;
            sync_q      <= meta_q;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            held_q      <= stable_q;
            held_prev_q <= held_q;
            pulse_q     <= pulse_d;
        end
    end

    assign up_o        = pulse_q[0];
    assign down_o      = pulse_q[1];
    assign up_held_o   = held_q[0];
    assign down_held_o = held_q[1];

endmodule
